// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Fixed 33-cycle latency (32 iterations plus a sign fix-up edge). Start is ignored while Busy is high.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             HiWrite,
  input  logic             LoWrite,
  input  logic [WIDTH-1:0] WriteData,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_SIGN
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic                 r_is_div;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic                 r_div_zero;
  logic [WIDTH-1:0]     r_a_orig;
  logic [WIDTH-1:0]     r_mcand;
  logic [2*WIDTH-1:0]   r_acc;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_dz;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  logic                 w_signed;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_next;
  logic [WIDTH:0]       w_trial;
  logic [2*WIDTH-1:0]   w_div_next;
  logic [2*WIDTH-1:0]   w_prod_fix;
  logic [WIDTH-1:0]     w_quo_fix;
  logic [WIDTH-1:0]     w_rem_fix;

  // Op[0]=0 selects the signed variants; the datapath always works on magnitudes.
  assign w_signed = ~Op[0];
  assign w_a_neg  = w_signed & A[WIDTH-1];
  assign w_b_neg  = w_signed & B[WIDTH-1];
  assign w_mag_a  = w_a_neg ? -A : A;
  assign w_mag_b  = w_b_neg ? -B : B;

  // Shift-add: upper half accumulates, lower half shifts the multiplier out.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring divide: upper half is the partial remainder, lower half dividend/quotient.
  assign w_trial    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]} - {1'b0, r_mcand};
  assign w_div_next = w_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                     : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
  assign w_quo_fix  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem_fix  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
      r_a_orig   <= '0;
      r_mcand    <= '0;
      r_acc      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dz       <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_is_div   <= Op[1];
            r_neg_q    <= w_a_neg ^ w_b_neg;
            r_neg_r    <= w_a_neg;
            r_div_zero <= Op[1] & (B == '0);
            r_a_orig   <= A;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_CALC;
            if (Op[1]) begin
              r_mcand <= w_mag_b;
              r_acc   <= {{WIDTH{1'b0}}, w_mag_a};
            end else begin
              r_mcand <= w_mag_a;
              r_acc   <= {{WIDTH{1'b0}}, w_mag_b};
            end
          end else begin
            if (HiWrite) r_hi <= WriteData;
            if (LoWrite) r_lo <= WriteData;
          end
        end
        S_CALC: begin
          r_acc <= r_is_div ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) r_state <= S_SIGN;
        end
        S_SIGN: begin
          // Divide-by-zero returns all-ones quotient and the untouched dividend.
          if (r_div_zero) begin
            r_lo <= '1;
            r_hi <= r_a_orig;
          end else if (r_is_div) begin
            r_lo <= w_quo_fix;
            r_hi <= w_rem_fix;
          end else begin
            {r_hi, r_lo} <= w_prod_fix;
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_dz    <= r_div_zero;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Busy    = r_busy;
  assign Done    = r_done;
  assign DivZero = r_dz;
  assign Hi      = r_hi;
  assign Lo      = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table, random ops against a native-arithmetic model,
// and hand-written sequences for busy-ignore, MTHI/MTLO and mid-operation reset.
module tb_mult_div_unit;
  localparam int W = 32;

  logic          Clk = 1'b0;
  logic          Rst, Start, HiWrite, LoWrite;
  logic [1:0]    Op;
  logic [W-1:0]  A, B, WriteData;
  logic          Busy, Done, DivZero;
  logic [W-1:0]  Hi, Lo;

  mult_div_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
    .HiWrite(HiWrite), .LoWrite(LoWrite), .WriteData(WriteData),
    .Busy(Busy), .Done(Done), .DivZero(DivZero), .Hi(Hi), .Lo(Lo)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  vec_t scb[$];
  vec_t tbl[10];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    vec_t v;
    logic signed [63:0] sa, sbv, q, r, p;
    v.op = op; v.a = a; v.b = b; v.dz = 1'b0;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    if (!op[1]) begin
      if (op[0]) p = {32'b0, a} * {32'b0, b};
      else       p = sa * sbv;
      v.hi = p[63:32];
      v.lo = p[31:0];
    end else if (b == 0) begin
      v.lo = 32'hFFFFFFFF;
      v.hi = a;
      v.dz = 1'b1;
    end else if (op[0]) begin
      v.lo = a / b;
      v.hi = a % b;
    end else begin
      q = sa / sbv;
      r = sa % sbv;
      v.lo = q[31:0];
      v.hi = r[31:0];
    end
    return v;
  endfunction

  // Scoreboard side: every Done pops one expected result.
  always @(negedge Clk) begin
    vec_t e;
    if (Done) begin
      if (scb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = scb.pop_front();
        chk("hi", Hi, e.hi);
        chk("lo", Lo, e.lo);
        chk("divzero", DivZero, e.dz);
      end
    end else if (DivZero) begin
      chk("divzero_without_done", DivZero, 1'b0);
    end
  end

  // Called at a negedge; leaves Start low at the following negedge.
  task automatic launch(input vec_t v);
    Start = 1'b1; Op = v.op; A = v.a; B = v.b;
    scb.push_back(v);
    @(negedge Clk);
    Start = 1'b0;
  endtask

  // Counts Busy cycles from the current negedge until Done appears.
  task automatic wait_done(input string name, input int exp_busy);
    int n;
    bit seen;
    n = 0; seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (Done) begin seen = 1; break; end
      if (Busy) n++;
      @(negedge Clk);
    end
    chk({name, "_done_seen"}, seen, 1'b1);
    chk({name, "_busy_cycles"}, n, exp_busy);
  endtask

  initial begin
    vec_t v;
    tbl[0] = '{2'b00, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    tbl[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    tbl[2] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    tbl[3] = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    tbl[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    tbl[5] = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    tbl[6] = '{2'b11, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1};
    tbl[7] = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    tbl[8] = '{2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    tbl[9] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};

    Rst = 1'b0; Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
    Op = 2'b00; A = '0; B = '0; WriteData = '0;
    repeat (2) @(negedge Clk);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_dz", DivZero, 1'b0);
    chk("rst_hi", Hi, 32'd0);
    chk("rst_lo", Lo, 32'd0);
    Rst = 1'b1;
    @(negedge Clk);

    // Back-to-back: each new op is launched in the previous op's Done cycle.
    for (int i = 0; i < 10; i++) begin
      launch(tbl[i]);
      wait_done($sformatf("tbl%0d", i), 33);
    end

    for (int i = 0; i < 12; i++) begin
      logic [1:0]   op;
      logic [W-1:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 :
           ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      launch(model(op, a, b));
      wait_done($sformatf("rnd%0d", i), 33);
    end
    @(negedge Clk);

    // MTHI/MTLO to known values, then prove a busy operation ignores Start and HiWrite.
    HiWrite = 1'b1; LoWrite = 1'b1; WriteData = 32'h11111111;
    @(negedge Clk);
    LoWrite = 1'b0; WriteData = 32'h22222222;
    @(negedge Clk);
    HiWrite = 1'b0;
    chk("mthi_only_hi", Hi, 32'h22222222);
    chk("mthi_only_lo", Lo, 32'h11111111);

    launch(tbl[5]);
    repeat (4) @(negedge Clk);
    Start = 1'b1; Op = 2'b00; A = 32'd1; B = 32'd1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (2) @(negedge Clk);
    HiWrite = 1'b1; WriteData = 32'h1234;
    @(negedge Clk);
    HiWrite = 1'b0;
    chk("busy_hi_hold", Hi, 32'h22222222);
    chk("busy_lo_hold", Lo, 32'h11111111);
    wait_done("busy_ignore", 25);
    @(negedge Clk);

    HiWrite = 1'b1; LoWrite = 1'b1; WriteData = 32'hABCD;
    @(negedge Clk);
    HiWrite = 1'b0; LoWrite = 1'b0;
    chk("mthilo_hi", Hi, 32'hABCD);
    chk("mthilo_lo", Lo, 32'hABCD);

    // Start beats a simultaneous MTHI.
    HiWrite = 1'b1; WriteData = 32'hDEAD;
    v = model(2'b01, 32'd3, 32'd4);
    launch(v);
    HiWrite = 1'b0;
    chk("start_wins_hi", Hi, 32'hABCD);
    wait_done("start_wins", 33);
    @(negedge Clk);

    // Reset in the middle of a MULT discards it; a new op right after release completes.
    launch(tbl[0]);
    repeat (9) @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
    scb.delete();
    chk("midrst_busy", Busy, 1'b0);
    chk("midrst_done", Done, 1'b0);
    chk("midrst_hi", Hi, 32'd0);
    chk("midrst_lo", Lo, 32'd0);
    launch(tbl[3]);
    wait_done("post_rst", 33);
    repeat (40) @(negedge Clk);

    chk("scoreboard_empty", scb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
